fft_frame_sequencer: RTL and testbench

Frame controller sitting between the sample source (audio/Lorenz sample stream) and the variable-size streaming FFT core. It chops a continuous complex sample stream into frames of a run-time-selected power-of-two length, drives the core's Avalon-ST sink with correct sop/eop, holds `fftpts_in`/`inverse` stable per frame, and limits frames in flight. On the output side it checks frame framing, tags each result with its bin index, and forwards it downstream with backpressure.

---
 rtl/fft_seq_pkg.sv | 19 +
 rtl/st_skid_reg.sv | 35 +++
 rtl/fft_frame_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the FFT frame sequencer.
// Frame lengths must be a power of two within the range the core supports.
package fft_seq_pkg;

  localparam int unsigned PTS_W   = 11;
  localparam int unsigned MIN_PTS = 8;

  typedef enum logic [0:0] {
    StIdle,
    StFeed
  } in_state_e;

  function automatic logic pts_legal(logic [31:0] pts, int unsigned pts_w, int unsigned min_pts);
    logic pow2;
    pow2 = (pts != 32'd0) && ((pts & (pts - 32'd1)) == 32'd0);
    return pow2 && (pts >= min_pts) && (pts <= (32'd1 << (pts_w - 1)));
  endfunction

endpackage

// File: rtl/st_skid_reg.sv
// One-entry valid/ready pipeline register; accepts a new beat whenever empty
// or when the held beat is leaving in the same cycle.
module st_skid_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (valid_i && ready_o) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames a continuous sample stream for a variable-size streaming FFT core and
// tags, checks and forwards the core's results with a bounded number of frames in flight.
module fft_frame_sequencer #(
  parameter int unsigned DIN_W        = 18,
  parameter int unsigned DOUT_W       = 29,
  parameter int unsigned PTS_W        = fft_seq_pkg::PTS_W,
  parameter int unsigned MIN_PTS      = fft_seq_pkg::MIN_PTS,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic [PTS_W-1:0]  cfg_pts,
  input  logic              cfg_inverse,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN_W-1:0]  in_real,
  input  logic [DIN_W-1:0]  in_imag,
  output logic              fft_sink_valid,
  output logic              fft_sink_sop,
  output logic              fft_sink_eop,
  input  logic              fft_sink_ready,
  output logic [DIN_W-1:0]  fft_sink_real,
  output logic [DIN_W-1:0]  fft_sink_imag,
  output logic [1:0]        fft_sink_error,
  output logic [PTS_W-1:0]  fft_fftpts_in,
  output logic              fft_inverse,
  input  logic              fft_source_valid,
  input  logic              fft_source_sop,
  input  logic              fft_source_eop,
  input  logic [1:0]        fft_source_error,
  input  logic [DOUT_W-1:0] fft_source_real,
  input  logic [DOUT_W-1:0] fft_source_imag,
  input  logic [PTS_W-1:0]  fft_fftpts_out,
  output logic              fft_source_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] out_real,
  output logic [DOUT_W-1:0] out_imag,
  output logic [PTS_W-1:0]  out_bin,
  output logic              out_last,
  output logic              busy,
  output logic              frame_err,
  output logic              err_sticky,
  output logic [15:0]       frames_done
);
  import fft_seq_pkg::*;

  localparam int unsigned IfW   = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned SinkW = 2 + 2 * DIN_W;
  localparam int unsigned OutW  = 1 + PTS_W + 2 * DOUT_W;

  localparam logic [PTS_W-1:0] PtsOne = PTS_W'(1);
  localparam logic [IfW-1:0]   MaxIf  = IfW'(MAX_INFLIGHT);

  in_state_e        state_q;
  logic [PTS_W-1:0] icnt_q, pts_q;
  logic             inv_q;
  logic [IfW-1:0]   inflight_q;
  logic [PTS_W-1:0] ocnt_q, nout_q, ocnt_d, bin, nout;
  logic             frame_err_q, err_sticky_q;
  logic [15:0]      frames_done_q;

  logic feed, cfg_ok, start, cfg_bad;
  logic sink_in_valid, sink_in_ready, in_fire, in_sop, in_eop;
  logic src_fire, fault, inc, dec, out_fire_last;
  logic [SinkW-1:0] sink_data;
  logic [OutW-1:0]  out_data;

  // Input side
  assign feed     = (state_q == StFeed);
  assign cfg_ok   = pts_legal(32'(cfg_pts), PTS_W, MIN_PTS);
  assign cfg_bad  = (state_q == StIdle) && run && !cfg_ok;
  // New settings only take effect once the previous frame's last sink beat is leaving.
  assign start    = (state_q == StIdle) && run && cfg_ok && (inflight_q < MaxIf) &&
                    (!fft_sink_valid || fft_sink_ready);
  assign in_ready = feed && sink_in_ready;
  assign in_fire  = in_valid && in_ready;
  assign in_sop   = (icnt_q == '0);
  assign in_eop   = (icnt_q == pts_q - PtsOne);
  assign sink_in_valid = in_valid && feed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      icnt_q  <= '0;
      pts_q   <= PTS_W'(MIN_PTS);
      inv_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFeed;
            icnt_q  <= '0;
            pts_q   <= cfg_pts;
            inv_q   <= cfg_inverse;
          end
        end
        StFeed: begin
          if (in_fire) begin
            if (in_eop) begin
              state_q <= StIdle;
              icnt_q  <= '0;
            end else begin
              icnt_q <= icnt_q + PtsOne;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  st_skid_reg #(.Width(SinkW)) u_sink_reg (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (sink_in_valid),
    .ready_o (sink_in_ready),
    .data_i  ({in_sop, in_eop, in_real, in_imag}),
    .valid_o (fft_sink_valid),
    .ready_i (fft_sink_ready),
    .data_o  (sink_data)
  );

  assign {fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag} = sink_data;
  assign fft_sink_error = 2'b00;
  assign fft_fftpts_in  = pts_q;
  assign fft_inverse    = inv_q;

  // Output side
  assign src_fire = fft_source_valid && fft_source_ready;
  assign bin      = fft_source_sop ? '0 : ocnt_q;
  assign nout     = fft_source_sop ? fft_fftpts_out : nout_q;

  always_comb begin
    fault  = 1'b0;
    ocnt_d = bin + PtsOne;
    if (fft_source_error != 2'b00) fault = 1'b1;
    if (fft_source_sop && (ocnt_q != '0)) fault = 1'b1;
    if (fft_source_eop && (bin != nout - PtsOne)) fault = 1'b1;
    if (!fft_source_eop && (bin == nout - PtsOne)) fault = 1'b1;
    // A frame that overruns its length restarts numbering rather than counting on.
    if (fft_source_eop || (bin == nout - PtsOne)) ocnt_d = '0;
  end

  st_skid_reg #(.Width(OutW)) u_out_reg (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (fft_source_valid),
    .ready_o (fft_source_ready),
    .data_i  ({fft_source_eop, bin, fft_source_real, fft_source_imag}),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (out_data)
  );

  assign {out_last, out_bin, out_real, out_imag} = out_data;

  assign inc           = fft_sink_valid && fft_sink_ready && fft_sink_sop;
  assign out_fire_last = out_valid && out_ready && out_last;
  // Stray result frames never started here must not underflow the count.
  assign dec           = out_fire_last && (inflight_q != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ocnt_q        <= '0;
      nout_q        <= PTS_W'(MIN_PTS);
      inflight_q    <= '0;
      frame_err_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      frames_done_q <= '0;
    end else begin
      if (src_fire) begin
        ocnt_q <= ocnt_d;
        if (fft_source_sop) nout_q <= fft_fftpts_out;
      end
      if (inc && !dec) begin
        inflight_q <= inflight_q + IfW'(1);
      end else if (dec && !inc) begin
        inflight_q <= inflight_q - IfW'(1);
      end
      frame_err_q  <= src_fire && fault;
      err_sticky_q <= err_sticky_q || (src_fire && fault) || cfg_bad;
      if (out_fire_last) frames_done_q <= frames_done_q + 16'd1;
    end
  end

  assign busy        = feed || (inflight_q != '0);
  assign frame_err   = frame_err_q;
  assign err_sticky  = err_sticky_q;
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: framing, flow control, in-flight limit,
// illegal configuration, fault reporting and mid-frame reset.
module tb_fft_frame_sequencer;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic [10:0] cfg_pts;
  logic        cfg_inverse;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_real, in_imag;
  logic        fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_ready;
  logic [17:0] fft_sink_real, fft_sink_imag;
  logic [1:0]  fft_sink_error;
  logic [10:0] fft_fftpts_in;
  logic        fft_inverse;
  logic        fft_source_valid, fft_source_sop, fft_source_eop;
  logic [1:0]  fft_source_error;
  logic [28:0] fft_source_real, fft_source_imag;
  logic [10:0] fft_fftpts_out;
  logic        fft_source_ready;
  logic        out_valid, out_ready;
  logic [28:0] out_real, out_imag;
  logic [10:0] out_bin;
  logic        out_last, busy, frame_err, err_sticky;
  logic [15:0] frames_done;

  int n_cmp;
  int n_err;

  fft_frame_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .run              (run),
    .cfg_pts          (cfg_pts),
    .cfg_inverse      (cfg_inverse),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_real          (in_real),
    .in_imag          (in_imag),
    .fft_sink_valid   (fft_sink_valid),
    .fft_sink_sop     (fft_sink_sop),
    .fft_sink_eop     (fft_sink_eop),
    .fft_sink_ready   (fft_sink_ready),
    .fft_sink_real    (fft_sink_real),
    .fft_sink_imag    (fft_sink_imag),
    .fft_sink_error   (fft_sink_error),
    .fft_fftpts_in    (fft_fftpts_in),
    .fft_inverse      (fft_inverse),
    .fft_source_valid (fft_source_valid),
    .fft_source_sop   (fft_source_sop),
    .fft_source_eop   (fft_source_eop),
    .fft_source_error (fft_source_error),
    .fft_source_real  (fft_source_real),
    .fft_source_imag  (fft_source_imag),
    .fft_fftpts_out   (fft_fftpts_out),
    .fft_source_ready (fft_source_ready),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_real         (out_real),
    .out_imag         (out_imag),
    .out_bin          (out_bin),
    .out_last         (out_last),
    .busy             (busy),
    .frame_err        (frame_err),
    .err_sticky       (err_sticky),
    .frames_done      (frames_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_idle();
    run = 1'b0; cfg_pts = 11'd16; cfg_inverse = 1'b0;
    in_valid = 1'b0; in_real = '0; in_imag = '0; fft_sink_ready = 1'b1;
    fft_source_valid = 1'b0; fft_source_sop = 1'b0; fft_source_eop = 1'b0;
    fft_source_error = 2'b00; fft_source_real = '0; fft_source_imag = '0;
    fft_fftpts_out = 11'd16; out_ready = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    n_cmp++; if (fft_sink_valid !== 1'b0) begin n_err++; $display("FAIL rst_sink_valid got %b want 0", fft_sink_valid); end
    n_cmp++; if ({fft_sink_sop, fft_sink_eop} !== 2'b00) begin n_err++; $display("FAIL rst_sop_eop got %b want 00", {fft_sink_sop, fft_sink_eop}); end
    n_cmp++; if (fft_sink_real !== 18'd0) begin n_err++; $display("FAIL rst_sink_real got %0d want 0", fft_sink_real); end
    n_cmp++; if (fft_fftpts_in !== 11'd8) begin n_err++; $display("FAIL rst_fftpts_in got %0d want 8", fft_fftpts_in); end
    n_cmp++; if (fft_inverse !== 1'b0) begin n_err++; $display("FAIL rst_inverse got %b want 0", fft_inverse); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_bin !== 11'd0) begin n_err++; $display("FAIL rst_out_bin got %0d want 0", out_bin); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if ({frame_err, err_sticky} !== 2'b00) begin n_err++; $display("FAIL rst_err got %b want 00", {frame_err, err_sticky}); end
    n_cmp++; if (frames_done !== 16'd0) begin n_err++; $display("FAIL rst_frames_done got %0d want 0", frames_done); end
    n_cmp++; if (fft_sink_error !== 2'b00) begin n_err++; $display("FAIL rst_sink_error got %b want 00", fft_sink_error); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Two 16-point frames of a 0..31 ramp with the core always ready.
  task automatic test_two_frames();
    int idx, got, in_cyc, sink_cyc;
    idx = 0; got = 0; in_cyc = -1; sink_cyc = -1;
    cfg_pts = 11'd16; run = 1'b1; fft_sink_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 32; cyc++) begin
      @(negedge clk);
      in_valid = (idx < 32); in_real = 18'(idx); in_imag = 18'(idx + 100);
      #1;
      if (in_valid && in_ready) begin
        if (in_cyc < 0) in_cyc = cyc;
        idx++;
      end
      if (fft_sink_valid && fft_sink_ready) begin
        if (sink_cyc < 0) sink_cyc = cyc;
        n_cmp++; if (fft_sink_real !== 18'(got) || fft_sink_imag !== 18'(got + 100)) begin
          n_err++; $display("FAIL ramp_data beat %0d got %0d/%0d want %0d/%0d", got, fft_sink_real, fft_sink_imag, got, got + 100); end
        n_cmp++; if (fft_sink_sop !== (got % 16 == 0) || fft_sink_eop !== (got % 16 == 15)) begin
          n_err++; $display("FAIL ramp_sop_eop beat %0d got %b%b", got, fft_sink_sop, fft_sink_eop); end
        n_cmp++; if (fft_fftpts_in !== 11'd16) begin
          n_err++; $display("FAIL ramp_fftpts beat %0d got %0d want 16", got, fft_fftpts_in); end
        got++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 32) begin n_err++; $display("FAIL ramp_count got %0d want 32", got); end
    n_cmp++; if (sink_cyc - in_cyc != 1) begin n_err++; $display("FAIL ramp_latency got %0d want 1", sink_cyc - in_cyc); end
  endtask

  // Two frames are in flight: a third may not start until a result frame drains.
  task automatic test_inflight_limit();
    int k, j;
    bit early, seen;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b0 || fft_sink_valid !== 1'b0) begin
        n_err++; $display("FAIL limit_hold cyc %0d in_ready %b sink_valid %b want 0 0", cyc, in_ready, fft_sink_valid); end
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL limit_busy got %b want 1", busy); end
    k = 0; j = 0; early = 1'b0; seen = 1'b0;
    out_ready = 1'b1; fft_fftpts_out = 11'd16;
    for (int cyc = 0; cyc < 80 && !seen; cyc++) begin
      @(negedge clk);
      fft_source_valid = (k < 16); fft_source_sop = (k == 0); fft_source_eop = (k == 15);
      fft_source_real = 29'(k * 5 + 7); fft_source_imag = 29'(k);
      #1;
      if (in_ready) begin
        if (j < 16) early = 1'b1;
        seen = 1'b1;
      end
      if (fft_source_valid && fft_source_ready) k++;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_bin !== 11'(j) || out_real !== 29'(j * 5 + 7) || out_last !== (j == 15)) begin
          n_err++; $display("FAIL limit_out beat %0d got bin %0d real %0d last %b", j, out_bin, out_real, out_last); end
        j++;
      end
    end
    fft_source_valid = 1'b0; fft_source_sop = 1'b0; fft_source_eop = 1'b0;
    n_cmp++; if (early) begin n_err++; $display("FAIL limit_early got in_ready before eop want none"); end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL limit_release got no in_ready want in_ready"); end
    n_cmp++; if (j != 16) begin n_err++; $display("FAIL limit_out_count got %0d want 16", j); end
    n_cmp++; if (frames_done !== 16'd1) begin n_err++; $display("FAIL limit_frames_done got %0d want 1", frames_done); end
  endtask

  // Third frame fed to beat 5, then reset; the next frame must restart at sop.
  task automatic test_reset_midframe();
    int idx, got;
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; in_real = 18'(300 + idx);
      #1;
      if (in_valid && in_ready) idx++;
      if (fft_sink_valid && fft_sink_ready) begin
        if (got == 0) begin
          n_cmp++; if (fft_sink_sop !== 1'b1 || fft_sink_real !== 18'd300) begin
            n_err++; $display("FAIL third_sop got sop %b real %0d want 1 300", fft_sink_sop, fft_sink_real); end
        end
        got++;
      end
    end
    n_cmp++; if (idx != 5) begin n_err++; $display("FAIL third_accept got %0d want 5", idx); end
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if ({fft_sink_valid, fft_sink_sop, in_ready, out_valid, busy} !== 5'b00000) begin
      n_err++; $display("FAIL midrst_flags got %b want 00000", {fft_sink_valid, fft_sink_sop, in_ready, out_valid, busy}); end
    n_cmp++; if (fft_fftpts_in !== 11'd8 || frames_done !== 16'd0) begin
      n_err++; $display("FAIL midrst_regs got pts %0d done %0d want 8 0", fft_fftpts_in, frames_done); end
    @(negedge clk);
    reset_n = 1'b1;
    idx = 0; got = 0; cfg_pts = 11'd16; run = 1'b1;
    for (int cyc = 0; cyc < 20 && got == 0; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; in_real = 18'(400 + idx);
      #1;
      if (in_valid && in_ready) idx++;
      if (fft_sink_valid && fft_sink_ready) begin
        n_cmp++; if (fft_sink_sop !== 1'b1 || fft_sink_real !== 18'd400 || fft_fftpts_in !== 11'd16) begin
          n_err++; $display("FAIL midrst_restart got sop %b real %0d pts %0d want 1 400 16", fft_sink_sop, fft_sink_real, fft_fftpts_in); end
        got++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 1) begin n_err++; $display("FAIL midrst_restart_seen got %0d want 1", got); end
  endtask

  // Toggling sink ready on the way in, random downstream ready on the way out.
  task automatic test_backpressure();
    int idx, got, k, j, pulses;
    bit hold_v;
    logic [28:0] hold_real;
    logic [10:0] hold_bin;
    apply_reset();
    cfg_pts = 11'd16; run = 1'b1;
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      @(negedge clk);
      fft_sink_ready = (cyc % 2 == 1); in_valid = (idx < 16); in_real = 18'(idx * 3);
      if (idx >= 16) run = 1'b0;
      #1;
      if (in_valid && in_ready) idx++;
      if (fft_sink_valid && fft_sink_ready) begin
        n_cmp++; if (fft_sink_real !== 18'(got * 3) || fft_sink_sop !== (got == 0) || fft_sink_eop !== (got == 15)) begin
          n_err++; $display("FAIL bp_sink beat %0d got real %0d sop %b eop %b", got, fft_sink_real, fft_sink_sop, fft_sink_eop); end
        got++;
      end
    end
    fft_sink_ready = 1'b1; run = 1'b0; in_valid = 1'b0;
    n_cmp++; if (got != 16) begin n_err++; $display("FAIL bp_sink_count got %0d want 16", got); end
    k = 0; j = 0; pulses = 0; hold_v = 1'b0; hold_real = '0; hold_bin = '0;
    fft_fftpts_out = 11'd16;
    for (int cyc = 0; cyc < 300 && j < 16; cyc++) begin
      @(negedge clk);
      fft_source_valid = (k < 16); fft_source_sop = (k == 0); fft_source_eop = (k == 15);
      fft_source_real = 29'(k * 2); fft_source_imag = 29'(1000 - k);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (hold_v) begin
        n_cmp++; if (out_valid !== 1'b1 || out_real !== hold_real || out_bin !== hold_bin) begin
          n_err++; $display("FAIL bp_hold got valid %b real %0d bin %0d want 1 %0d %0d", out_valid, out_real, out_bin, hold_real, hold_bin); end
      end
      hold_v = out_valid && !out_ready; hold_real = out_real; hold_bin = out_bin;
      if (frame_err) pulses++;
      if (fft_source_valid && fft_source_ready) k++;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_bin !== 11'(j) || out_real !== 29'(j * 2) || out_imag !== 29'(1000 - j) || out_last !== (j == 15)) begin
          n_err++; $display("FAIL bp_out beat %0d got bin %0d real %0d imag %0d last %b", j, out_bin, out_real, out_imag, out_last); end
        j++;
      end
    end
    fft_source_valid = 1'b0; fft_source_sop = 1'b0; fft_source_eop = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (j != 16) begin n_err++; $display("FAIL bp_out_count got %0d want 16", j); end
    n_cmp++; if (frames_done !== 16'd1) begin n_err++; $display("FAIL bp_frames_done got %0d want 1", frames_done); end
    n_cmp++; if (pulses != 0 || err_sticky !== 1'b0) begin
      n_err++; $display("FAIL bp_no_err got pulses %0d sticky %b want 0 0", pulses, err_sticky); end
  endtask

  // A non-power-of-two length is refused; a legal one then starts normally.
  task automatic test_illegal_cfg();
    int idx, got;
    apply_reset();
    cfg_pts = 11'd12; cfg_inverse = 1'b1; run = 1'b1; in_valid = 1'b1; in_real = '0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b0 || fft_sink_valid !== 1'b0) begin
        n_err++; $display("FAIL bad_cfg_hold cyc %0d in_ready %b sink_valid %b want 0 0", cyc, in_ready, fft_sink_valid); end
    end
    n_cmp++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL bad_cfg_sticky got %b want 1", err_sticky); end
    cfg_pts = 11'd8; idx = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      in_valid = (idx < 8); in_real = 18'(idx + 50);
      if (idx >= 8) run = 1'b0;
      #1;
      if (in_valid && in_ready) idx++;
      if (fft_sink_valid && fft_sink_ready) begin
        n_cmp++; if (fft_sink_real !== 18'(got + 50) || fft_sink_sop !== (got == 0) || fft_sink_eop !== (got == 7)) begin
          n_err++; $display("FAIL cfg8_beat %0d got real %0d sop %b eop %b", got, fft_sink_real, fft_sink_sop, fft_sink_eop); end
        n_cmp++; if (fft_fftpts_in !== 11'd8 || fft_inverse !== 1'b1) begin
          n_err++; $display("FAIL cfg8_latch got pts %0d inv %b want 8 1", fft_fftpts_in, fft_inverse); end
        got++;
      end
    end
    in_valid = 1'b0; run = 1'b0;
    n_cmp++; if (got != 8) begin n_err++; $display("FAIL cfg8_count got %0d want 8", got); end
    n_cmp++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL cfg8_sticky got %b want 1", err_sticky); end
  endtask

  // Early eop in an 8-point frame, then a beat carrying a core error code.
  task automatic test_faults();
    int k, pulses, lastbin;
    apply_reset();
    out_ready = 1'b1; fft_fftpts_out = 11'd8;
    k = 0; pulses = 0; lastbin = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      fft_source_valid = (k < 7); fft_source_sop = (k == 0); fft_source_eop = (k == 6);
      fft_source_real = 29'(k);
      #1;
      if (frame_err) pulses++;
      if (fft_source_valid && fft_source_ready) k++;
      if (out_valid && out_ready && out_last) lastbin = int'(out_bin);
    end
    fft_source_valid = 1'b0; fft_source_sop = 1'b0; fft_source_eop = 1'b0;
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL early_eop_pulse got %0d want 1", pulses); end
    n_cmp++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL early_eop_sticky got %b want 1", err_sticky); end
    n_cmp++; if (lastbin != 6) begin n_err++; $display("FAIL early_eop_bin got %0d want 6", lastbin); end
    n_cmp++; if (frames_done !== 16'd1) begin n_err++; $display("FAIL early_eop_done got %0d want 1", frames_done); end
    apply_reset();
    fft_fftpts_out = 11'd8; k = 0; pulses = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      fft_source_valid = (k < 1); fft_source_sop = 1'b1; fft_source_eop = 1'b0;
      fft_source_error = (k < 1) ? 2'b01 : 2'b00;
      #1;
      if (frame_err) pulses++;
      if (fft_source_valid && fft_source_ready) k++;
    end
    fft_source_valid = 1'b0; fft_source_sop = 1'b0; fft_source_error = 2'b00;
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL src_error_pulse got %0d want 1", pulses); end
    n_cmp++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL src_error_sticky got %b want 1", err_sticky); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_two_frames();
    test_inflight_limit();
    test_reset_midframe();
    test_backpressure();
    test_illegal_cfg();
    test_faults();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
